// File: rtl/conv_layer_sched_if.sv
// conv_layer_sched_if: engine-side bus between the layer scheduler and the convolution datapath
interface conv_layer_sched_if #(
    parameter int SIZE_address_pix = 13,
    parameter int SIZE_address_wei = 9
);
    logic                        conv_en;
    logic [SIZE_address_pix-1:0] memstartp;
    logic [SIZE_address_wei-1:0] memstartw;
    logic [SIZE_address_pix-1:0] memstartzap;
    logic [4:0]                  lvl;
    logic [1:0]                  slvl;
    logic [4:0]                  filt;
    logic [4:0]                  matrix;
    logic                        bias;
    logic                        globmaxp_en;
    logic                        STOP;
    modport master (
        output conv_en, memstartp, memstartw, memstartzap, lvl, slvl, filt, matrix, bias, globmaxp_en,
        input  STOP
    );
    modport slave (
        input  conv_en, memstartp, memstartw, memstartzap, lvl, slvl, filt, matrix, bias, globmaxp_en,
        output STOP
    );
endinterface

// File: rtl/conv_layer_sched.sv
// conv_layer_sched: walks a conv layer as (group, channel) passes; optional watchdog via CONV_SCHED_WATCHDOG_EN
module conv_layer_sched #(
    parameter int SIZE_address_pix = 13,
    parameter int SIZE_address_wei = 9,
    parameter int GAP_CYCLES       = 1,
    parameter int WD_LIMIT         = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [4:0]                  in_ch_m1,
    input  logic [4:0]                  grp_m1,
    input  logic [4:0]                  matrix,
    input  logic [9:0]                  matrix2,
    input  logic [SIZE_address_pix-1:0] base_p,
    input  logic [SIZE_address_wei-1:0] base_w,
    input  logic [SIZE_address_pix-1:0] base_zap,
    input  logic                        globmaxp_req,
    conv_layer_sched_if.master          eng,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);
    localparam int P = SIZE_address_pix;
    localparam int W = SIZE_address_wei;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, DONE} state_t;
    state_t state, state_nx;
    logic [GW-1:0] gap_cnt;
    logic [4:0] f, c, in_ch_q, grp_q, matrix_q;
    logic [9:0] matrix2_q;
    logic [P-1:0] base_p_q, base_zap_q;
    logic [W-1:0] base_w_q;
    logic gmp_q, gap_last, last_ch, last_pass, wd_trip, clr;
    assign gap_last  = gap_cnt == GW'(GAP_CYCLES - 1);
    assign last_ch   = c == in_ch_q;
    assign last_pass = last_ch && f == grp_q;
    assign clr       = (state == GAP && gap_last && last_pass) || wd_trip;
`ifdef CONV_SCHED_WATCHDOG_EN
    localparam int WW = $clog2(WD_LIMIT + 1);
    logic [WW-1:0] wd_cnt;
    assign wd_trip = state == RUN && !eng.STOP && wd_cnt == WW'(WD_LIMIT - 1);
    // count RUN cycles of the current pass; restarted every LOAD
    always_ff @(posedge clk)
        if (rst || state == LOAD) wd_cnt <= '0;
        else if (state == RUN) wd_cnt <= wd_cnt + WW'(1);
    // abort flag stays set until the next accepted start or rst
    always_ff @(posedge clk)
        if (rst) err <= 1'b0;
        else if (state == IDLE && start) err <= 1'b0;
        else if (wd_trip) err <= 1'b1;
`else
    assign wd_trip = 1'b0;
    assign err     = 1'b0;
`endif
    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    // next state plus the state-decoded strobes
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? LOAD : IDLE;
            LOAD:    state_nx = RUN;
            RUN:     state_nx = wd_trip ? IDLE : eng.STOP ? GAP : RUN;
            GAP:     state_nx = !gap_last ? GAP : last_pass ? DONE : LOAD;
            default: state_nx = IDLE;
        endcase
        eng.conv_en = state == RUN;
        busy        = state == LOAD || state == RUN || state == GAP;
        done        = state == DONE;
    end
    // latched layer configuration, pass counters and gap timer
    always_ff @(posedge clk)
        if (rst) begin
            {f, c, in_ch_q, grp_q, matrix_q, matrix2_q, gmp_q} <= '0;
            {base_p_q, base_zap_q, base_w_q, gap_cnt} <= '0;
        end else begin
            if (state == IDLE && start) begin
                {f, c} <= '0;
                {in_ch_q, grp_q, matrix_q, matrix2_q, gmp_q} <= {in_ch_m1, grp_m1, matrix, matrix2, globmaxp_req};
                {base_p_q, base_zap_q, base_w_q} <= {base_p, base_zap, base_w};
            end
            if (state == GAP && gap_last) begin
                c <= last_ch ? 5'd0 : c + 5'd1;
                f <= last_ch ? f + 5'd1 : f;
            end
            gap_cnt <= state == GAP && !gap_last ? gap_cnt + GW'(1) : '0;
        end
    // per-pass engine controls, registered in LOAD and held through RUN/GAP
    always_ff @(posedge clk)
        if (rst || clr) begin
            {eng.memstartp, eng.memstartw, eng.memstartzap} <= '0;
            {eng.lvl, eng.slvl, eng.filt, eng.matrix, eng.bias, eng.globmaxp_en} <= '0;
        end else if (state == LOAD) begin
            eng.memstartp   <= base_p_q + P'(c) * P'(matrix2_q);
            eng.memstartw   <= base_w_q + W'(f) * (W'(in_ch_q) + W'(1)) + W'(c);
            eng.memstartzap <= base_zap_q + P'(f) * P'(matrix2_q);
            eng.lvl         <= c;
            eng.slvl        <= f[1:0];
            eng.filt        <= grp_q;
            eng.matrix      <= matrix_q;
            eng.bias        <= last_ch;
            eng.globmaxp_en <= gmp_q & last_ch;
        end
endmodule

// File: tb/tb_conv_layer_sched.sv
// tb_conv_layer_sched: table-driven and randomized layer runs checked against a pass-list model
module tb_conv_layer_sched;
    localparam int GAP = 1;
    localparam int WDL = 8;
`ifdef CONV_SCHED_WATCHDOG_EN
    localparam int R0 = 7;
`else
    localparam int R0 = 10;
`endif
    typedef struct {
        int in_m1, grp_m1, mat, m2, bp, bw, bz, gmp, run, stop_hi, passes, lat;
    } vec_t;
    logic clk = 0, rst = 1, start = 0, globmaxp_req = 0;
    logic [4:0] in_ch_m1 = 0, grp_m1 = 0, matrix = 0;
    logic [9:0] matrix2 = 0;
    logic [12:0] base_p = 0, base_zap = 0;
    logic [8:0] base_w = 0;
    logic busy, done, err;
    int cyc = 0, checks = 0, errors = 0;
    vec_t tbl[5];
    conv_layer_sched_if #(.SIZE_address_pix(13), .SIZE_address_wei(9)) bus();
    conv_layer_sched #(.SIZE_address_pix(13), .SIZE_address_wei(9), .GAP_CYCLES(GAP), .WD_LIMIT(WDL)) dut (
        .clk(clk), .rst(rst), .start(start), .in_ch_m1(in_ch_m1), .grp_m1(grp_m1), .matrix(matrix),
        .matrix2(matrix2), .base_p(base_p), .base_w(base_w), .base_zap(base_zap),
        .globmaxp_req(globmaxp_req), .eng(bus), .busy(busy), .done(done), .err(err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_conv_en"}, 32'(bus.conv_en), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_memstartp"}, 32'(bus.memstartp), 0);
        chk({tag, "_memstartw"}, 32'(bus.memstartw), 0);
        chk({tag, "_memstartzap"}, 32'(bus.memstartzap), 0);
        chk({tag, "_lvl_slvl_filt"}, 32'({bus.lvl, bus.slvl, bus.filt, bus.matrix}), 0);
        chk({tag, "_bias_gmp"}, 32'({bus.bias, bus.globmaxp_en}), 0);
    endtask

    task automatic scramble();
        in_ch_m1 = 5'($urandom); grp_m1 = 5'($urandom); matrix = 5'($urandom);
        matrix2 = 10'($urandom); base_p = 13'($urandom); base_w = 9'($urandom);
        base_zap = 13'($urandom); globmaxp_req = 1'($urandom);
    endtask

    task automatic drive_cfg(input vec_t v);
        in_ch_m1 = 5'(v.in_m1); grp_m1 = 5'(v.grp_m1); matrix = 5'(v.mat); matrix2 = 10'(v.m2);
        base_p = 13'(v.bp); base_w = 9'(v.bw); base_zap = 13'(v.bz); globmaxp_req = 1'(v.gmp);
    endtask

    // one full layer in lockstep: stray STOPs in LOAD/GAP, stray starts in RUN, config scrambled after start
    task automatic run_layer(input vec_t v);
        int t0, np, run, ep, ew, ez, eb;
        np = 0;
        run = v.stop_hi != 0 ? 1 : v.run;
        drive_cfg(v);
        start = 1;
        bus.STOP = v.stop_hi != 0;
        t0 = cyc;
        @(negedge clk);
        start = 0;
        scramble();
        for (int f = 0; f <= v.grp_m1; f++)
            for (int c = 0; c <= v.in_m1; c++) begin
                chk("load_conv_en", 32'(bus.conv_en), 0);
                chk("load_busy", 32'(busy), 1);
                bus.STOP = v.stop_hi != 0 ? 1'b1 : 1'($urandom);
                @(negedge clk);
                np++;
                ep = (v.bp + c * v.m2) % 8192;
                ew = (v.bw + f * (v.in_m1 + 1) + c) % 512;
                ez = (v.bz + f * v.m2) % 8192;
                eb = c == v.in_m1 ? 1 : 0;
                chk("pass_memstartw", 32'(bus.memstartw), ew);
                chk("pass_memstartzap", 32'(bus.memstartzap), ez);
                chk("pass_lvl", 32'(bus.lvl), c);
                chk("pass_slvl", 32'(bus.slvl), f % 4);
                chk("pass_filt", 32'(bus.filt), v.grp_m1);
                chk("pass_matrix", 32'(bus.matrix), v.mat);
                chk("pass_bias", 32'(bus.bias), eb);
                chk("pass_globmaxp_en", 32'(bus.globmaxp_en), v.gmp != 0 ? eb : 0);
                for (int k = 1; k <= run; k++) begin
                    chk("run_conv_en", 32'(bus.conv_en), 1);
                    chk("run_memstartp", 32'(bus.memstartp), ep);
                    bus.STOP = v.stop_hi != 0 || k == run;
                    start = 1'($urandom);
                    @(negedge clk);
                end
                start = 0;
                for (int g = 0; g < GAP; g++) begin
                    chk("gap_conv_en", 32'(bus.conv_en), 0);
                    chk("gap_busy", 32'(busy), 1);
                    bus.STOP = v.stop_hi != 0 ? 1'b1 : 1'($urandom);
                    @(negedge clk);
                end
            end
        bus.STOP = 0;
        chk("done_pulse", 32'(done), 1);
        chk("done_err", 32'(err), 0);
        chk_idle_outputs("done");
        chk("passes", 32'(np), v.passes);
        chk("latency", 32'(cyc - t0 + 1), v.lat);
        @(negedge clk);
        chk("after_done", 32'(done), 0);
        chk("after_busy", 32'(busy), 0);
    endtask

    initial begin
        vec_t v;
        bus.STOP = 0;
        tbl[0] = '{0, 0, 28, 784, 100, 5, 400, 0, R0, 0, 1, R0 + 4};
        tbl[1] = '{2, 1, 4, 16, 0, 0, 200, 0, 3, 0, 6, 32};
        tbl[2] = '{1, 0, 5, 25, 7, 3, 50, 1, 2, 0, 2, 10};
        tbl[3] = '{1, 1, 3, 9, 11, 20, 30, 1, 1, 1, 4, 14};
        tbl[4] = '{3, 0, 31, 1000, 8000, 510, 8191, 0, 1, 0, 4, 14};
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_done_err", 32'({done, err}), 0);
        rst = 0;
        @(negedge clk);
        foreach (tbl[i]) run_layer(tbl[i]);
        // reset during RUN of pass 2, then a fresh start must begin at pass 1
        drive_cfg(tbl[1]);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int n = 1; n <= 6; n++) begin
            bus.STOP = n == 4;
            @(negedge clk);
        end
        chk("rst_pre_conv_en", 32'(bus.conv_en), 1);
        chk("rst_pre_lvl", 32'(bus.lvl), 1);
        rst = 1;
        @(negedge clk);
        chk_idle_outputs("rst_mid");
        chk("rst_mid_done", 32'(done), 0);
        rst = 0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_done", 32'({done, busy}), 0);
        end
        run_layer(tbl[1]);
`ifdef CONV_SCHED_WATCHDOG_EN
        drive_cfg(tbl[0]);
        bus.STOP = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int k = 1; k <= WDL; k++) begin
            @(negedge clk);
            chk("wd_run_conv_en", 32'(bus.conv_en), 1);
        end
        @(negedge clk);
        chk("wd_err", 32'(err), 1);
        chk("wd_conv_en", 32'(bus.conv_en), 0);
        chk("wd_busy_done", 32'({busy, done}), 0);
        repeat (3) @(negedge clk);
        chk("wd_err_sticky", 32'({err, done}), 2);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("wd_err_clear", 32'(err), 0);
        bus.STOP = 1;
        repeat (3) @(negedge clk);
        bus.STOP = 0;
        chk("wd_restart_done", 32'(done), 1);
        @(negedge clk);
`endif
        for (int r = 0; r < 8; r++) begin
            v.in_m1 = $urandom_range(0, 3);
            v.grp_m1 = $urandom_range(0, 5);
            v.mat = $urandom_range(1, 31);
            v.m2 = v.mat * v.mat;
            v.bp = $urandom_range(0, 8191);
            v.bw = $urandom_range(0, 511);
            v.bz = $urandom_range(0, 8191);
            v.gmp = $urandom_range(0, 1);
            v.run = $urandom_range(1, 5);
            v.stop_hi = $urandom_range(0, 3) == 0 ? 1 : 0;
            v.passes = (v.in_m1 + 1) * (v.grp_m1 + 1);
            v.lat = v.passes * (1 + (v.stop_hi != 0 ? 1 : v.run) + GAP) + 2;
            run_layer(v);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_layer_sched.md
Name: conv_layer_sched

Overview:
- Layer-level scheduler for the convolution engine.
- Walks one convolution layer as a sequence of passes, each pass being (filter group f, input channel c).
- Per pass: drives the engine's base addresses, level, slice and bias controls; pulses conv_en; waits for STOP.
- Sits between the top-level network sequencer (start/done) and the convolution datapath.

Parameters:
- SIZE_address_pix, 13, width of pixel-memory addresses.
- SIZE_address_wei, 9, width of weight-memory addresses.
- GAP_CYCLES, 1, cycles conv_en is held low between passes; minimum 1, so the engine clears its counters.
- WD_LIMIT, 4096, watchdog limit in RUN cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  launch a layer; sampled only in IDLE.
- in_ch_m1  in  5  input channels minus 1.
- grp_m1  in  5  filter groups minus 1.
- matrix  in  5  feature-map side length; passed through.
- matrix2  in  10  feature-map area (matrix*matrix); used as channel stride.
- base_p  in  SIZE_address_pix  input map base address.
- base_w  in  SIZE_address_wei  weight base address.
- base_zap  in  SIZE_address_pix  output map base address.
- globmaxp_req  in  1  request global max-pool on final passes.
- STOP  in  1  engine pass complete.
- conv_en  out  1  engine enable.
- memstartp  out  SIZE_address_pix  per-pass input address.
- memstartw  out  SIZE_address_wei  per-pass weight address.
- memstartzap  out  SIZE_address_pix  per-pass output address.
- lvl  out  5  current input channel c.
- slvl  out  2  f mod 4.
- filt  out  5  equals grp_m1.
- bias  out  1  final-channel pass flag.
- globmaxp_en  out  1  global max-pool enable.
- busy  out  1  layer in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  watchdog abort, sticky.

Behaviour:
- Reset values: every output 0; FSM in IDLE; f=0, c=0. err is also cleared by rst.
- Configuration inputs are latched on the accepted start. Later changes to them are ignored until the next layer.
- FSM: IDLE -> LOAD -> RUN -> GAP -> LOAD/DONE -> IDLE.
- IDLE:
  - busy=0, conv_en=0.
  - start=1 latches configuration, clears f and c, clears err, goes to LOAD.
- LOAD (exactly 1 cycle):
  - busy=1, conv_en=0.
  - Registers memstartp = base_p + c*matrix2.
  - Registers memstartw = base_w + f*(in_ch_m1+1) + c.
  - Registers memstartzap = base_zap + f*matrix2.
  - Registers lvl=c, slvl=f[1:0], filt=grp_m1, bias=(c==in_ch_m1), globmaxp_en=globmaxp_req & bias.
  - All sums truncate modulo 2^width.
- RUN:
  - conv_en=1 from the first RUN cycle onward; all address and control outputs stay stable.
  - STOP=1 -> GAP; conv_en is 0 on the following cycle.
- GAP:
  - conv_en=0 for GAP_CYCLES cycles.
  - On the last GAP cycle: if c<in_ch_m1, c=c+1; else c=0 and f=f+1.
  - If c==in_ch_m1 and f==grp_m1 before the increment, go to DONE; otherwise go to LOAD.
- DONE: done=1 for exactly 1 cycle, busy=0, then IDLE. Outputs other than done/err return to 0.
- Pass count is (in_ch_m1+1)*(grp_m1+1). Latency from start to done is the sum over passes of (1 LOAD + RUN length + GAP_CYCLES), plus 2.
- STOP is ignored outside RUN. A STOP already high on RUN entry completes the pass after 1 cycle of conv_en.
- start is ignored while busy.
- rst mid-layer: conv_en drops on the next edge and all state clears. No done pulse is produced.
- Loop order: c is the inner loop, so lvl=0 starts each group (fresh accumulation) and bias marks the group's write-out pass.

Optional Feature:
- Macro: CONV_SCHED_WATCHDOG_EN.
- Defined:
  - A counter increments each RUN cycle and clears in LOAD.
  - If the counter reaches WD_LIMIT without STOP: err=1 (sticky until start or rst), conv_en=0, busy=0, FSM returns to IDLE with no done pulse.
- Undefined: no counter; err is tied to 0; RUN waits for STOP indefinitely.

Test Plan:
- Single pass:
  - Stimulus: in_ch_m1=0, grp_m1=0, base_p=100, base_w=5, base_zap=400, matrix2=784; STOP returned 10 cycles after conv_en.
  - Required: memstartp=100, memstartw=5, memstartzap=400, lvl=0, bias=1; exactly one conv_en high window; done exactly 1 cycle after GAP; busy low afterward.
- Multi-channel, multi-group:
  - Stimulus: in_ch_m1=2, grp_m1=1, matrix2=16, base_p=0, base_w=0.
  - Required: 6 passes with memstartp sequence 0,16,32,0,16,32; memstartw 0,1,2,3,4,5; lvl 0,1,2,0,1,2; bias only on passes 3 and 6; memstartzap base, base, base, base+16, base+16, base+16; slvl 0,0,0,1,1,1.
- Global max-pool:
  - Stimulus: globmaxp_req=1, in_ch_m1=1.
  - Required: globmaxp_en=1 only on bias passes.
- Handshake edges:
  - Stimulus: start pulsed while busy; STOP asserted during LOAD/GAP; STOP high on RUN entry.
  - Required: second start ignored; stray STOPs ignored; pass ends after 1 conv_en cycle; conv_en low at least GAP_CYCLES between passes.
- Reset mid-layer:
  - Stimulus: rst during RUN of pass 2.
  - Required: next cycle conv_en=0, busy=0, all outputs 0, no done; a fresh start re-runs from pass 1.
- Watchdog (CONV_SCHED_WATCHDOG_EN, WD_LIMIT=8):
  - Stimulus: STOP never asserted.
  - Required: err=1 after 8 RUN cycles, conv_en drops, busy=0, no done; next start clears err.
